// File: rtl/hu_audiodec_pkg.sv
// Shared constants and types for the hu_audiodec load stage.
package hu_audiodec_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BURST_MAX_DEF  = 16;
    localparam int unsigned FIFO_DEPTH_DEF = 32;

    localparam logic [2:0] DMA_SIZE_WORD = 3'b010;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef struct packed {
        logic [WORD_W-1:0] index;
        logic [WORD_W-1:0] length;
    } dma_req_t;

    // Words in the next burst: remaining words clipped to the burst limit.
    function automatic logic [WORD_W-1:0] burst_len(input logic [WORD_W-1:0] rem,
                                                     input logic [WORD_W-1:0] bmax);
        return (rem < bmax) ? rem : bmax;
    endfunction

endpackage

// File: rtl/hu_audiodec_fifo.sv
// First-word fall-through FIFO; a pushed word is visible at pop_data one cycle later.
module hu_audiodec_fifo #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    // Head forced to zero when empty so the output is defined after reset.
    assign pop_data = empty ? '0 : mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/hu_audiodec_dma_load.sv
// Load stage: splits a (base, length) job into DMA read bursts and streams the words to the core.
module hu_audiodec_dma_load
    import hu_audiodec_pkg::*;
#(
    parameter int unsigned BURST_MAX  = BURST_MAX_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] cfg_base_index,
    input  logic [31:0] cfg_len,
    output logic        dma_read_ctrl_valid,
    input  logic        dma_read_ctrl_ready,
    output logic [31:0] dma_read_ctrl_data_index,
    output logic [31:0] dma_read_ctrl_data_length,
    output logic [2:0]  dma_read_ctrl_data_size,
    input  logic        dma_read_chnl_valid,
    output logic        dma_read_chnl_ready,
    input  logic [31:0] dma_read_chnl_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] debug
);

    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BEAT_W = $clog2(BURST_MAX) + 1;

    logic [1:0]        state_q,      state_d;
    logic [31:0]       idx_q,        idx_d;
    logic [31:0]       rem_q,        rem_d;
    logic [BEAT_W-1:0] beats_q,      beats_d;
    logic [15:0]       bursts_q,     bursts_d;
    dma_req_t          req_q,        req_d;
    logic              ctrl_valid_q, ctrl_valid_d;
    logic              chnl_ready_q, chnl_ready_d;
    logic              busy_q,       busy_d;
    logic              done_q,       done_d;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [31:0]       burst_c;
    logic [31:0]       free_c;
    logic [31:0]       rem_next_c;
    logic              push_c;
    logic              pop_c;

    assign burst_c    = burst_len(rem_q, 32'(BURST_MAX));
    assign free_c     = 32'(FIFO_DEPTH) - 32'(fifo_count);
    assign rem_next_c = rem_q - req_q.length;
    assign push_c     = dma_read_chnl_valid && dma_read_chnl_ready;
    assign pop_c      = out_valid && out_ready;

    hu_audiodec_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_c),
        .push_data (dma_read_chnl_data),
        .pop       (pop_c),
        .pop_data  (out_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        rem_d        = rem_q;
        beats_d      = beats_q;
        bursts_d     = bursts_q;
        req_d        = req_q;
        ctrl_valid_d = ctrl_valid_q;
        chnl_ready_d = chnl_ready_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_len != '0) begin
                        idx_d    = cfg_base_index;
                        rem_d    = cfg_len;
                        bursts_d = '0;
                        busy_d   = 1'b1;
                        state_d  = ST_REQ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                // Issue only once the whole burst fits; free space can only grow here.
                if (ctrl_valid_q) begin
                    if (dma_read_ctrl_ready) begin
                        ctrl_valid_d = 1'b0;
                        beats_d      = BEAT_W'(req_q.length);
                        chnl_ready_d = 1'b1;
                        state_d      = ST_DATA;
                    end
                end else if (free_c >= burst_c) begin
                    ctrl_valid_d = 1'b1;
                    req_d.index  = idx_q;
                    req_d.length = burst_c;
                end
            end
            ST_DATA: begin
                if (push_c) begin
                    beats_d = beats_q - BEAT_W'(1);
                    if (beats_q == BEAT_W'(1)) begin
                        rem_d        = rem_next_c;
                        idx_d        = idx_q + req_q.length;
                        bursts_d     = bursts_q + 16'd1;
                        chnl_ready_d = 1'b0;
                        state_d      = (rem_next_c != '0) ? ST_REQ : ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            rem_q        <= '0;
            beats_q      <= '0;
            bursts_q     <= '0;
            req_q        <= '0;
            ctrl_valid_q <= 1'b0;
            chnl_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            rem_q        <= rem_d;
            beats_q      <= beats_d;
            bursts_q     <= bursts_d;
            req_q        <= req_d;
            ctrl_valid_q <= ctrl_valid_d;
            chnl_ready_q <= chnl_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign dma_read_ctrl_valid       = ctrl_valid_q;
    assign dma_read_ctrl_data_index  = req_q.index;
    assign dma_read_ctrl_data_length = req_q.length;
    assign dma_read_ctrl_data_size   = DMA_SIZE_WORD;
    assign dma_read_chnl_ready       = chnl_ready_q && !fifo_full;
    assign out_valid                 = !fifo_empty;
    assign busy                      = busy_q;
    assign done                      = done_q;
    assign debug                     = {state_q, 14'd0, bursts_q};

endmodule

// File: tb/tb_hu_audiodec_dma_load.sv
// Directed bench for hu_audiodec_dma_load with a simple ESP DMA responder and output scoreboard.
module tb_hu_audiodec_dma_load;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] cfg_base_index;
    logic [31:0] cfg_len;
    logic        dma_read_ctrl_valid;
    logic        dma_read_ctrl_ready;
    logic [31:0] dma_read_ctrl_data_index;
    logic [31:0] dma_read_ctrl_data_length;
    logic [2:0]  dma_read_ctrl_data_size;
    logic        dma_read_chnl_valid;
    logic        dma_read_chnl_ready;
    logic [31:0] dma_read_chnl_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
    logic        done;
    logic [31:0] debug;

    int n_vec = 0;
    int n_err = 0;

    // bench knobs (written by the stimulus block only)
    logic out_en    = 1'b1;
    logic out_rand  = 1'b0;
    logic chnl_rand = 1'b0;

    // model state (written by the monitor only)
    int          occ;
    int          words;
    int          done_cnt;
    int          cur_beats;
    logic [31:0] cur_idx;
    logic [31:0] job_len;
    logic [31:0] exp_next;
    logic [31:0] req_log_idx[$];
    logic [31:0] req_log_len[$];
    logic [31:0] pend_idx[$];
    logic [31:0] pend_len[$];
    logic        pv_valid;
    logic        pv_ready;
    logic [31:0] pv_index;
    logic [31:0] pv_len;

    hu_audiodec_dma_load #(
        .BURST_MAX  (16),
        .FIFO_DEPTH (32)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .start                     (start),
        .cfg_base_index            (cfg_base_index),
        .cfg_len                   (cfg_len),
        .dma_read_ctrl_valid       (dma_read_ctrl_valid),
        .dma_read_ctrl_ready       (dma_read_ctrl_ready),
        .dma_read_ctrl_data_index  (dma_read_ctrl_data_index),
        .dma_read_ctrl_data_length (dma_read_ctrl_data_length),
        .dma_read_ctrl_data_size   (dma_read_ctrl_data_size),
        .dma_read_chnl_valid       (dma_read_chnl_valid),
        .dma_read_chnl_ready       (dma_read_chnl_ready),
        .dma_read_chnl_data        (dma_read_chnl_data),
        .out_valid                 (out_valid),
        .out_ready                 (out_ready),
        .out_data                  (out_data),
        .busy                      (busy),
        .done                      (done),
        .debug                     (debug)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] i);
        return (i * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Sample handshakes on the active edge (pre-update values) and keep the model current.
    always @(posedge clk) begin
        if (!rst) begin
            occ       = 0;
            words     = 0;
            done_cnt  = 0;
            cur_beats = 0;
            pv_valid  = 1'b0;
            pend_idx.delete();
            pend_len.delete();
        end else begin
            if (pv_valid && !pv_ready) begin
                chk("ctrl_stable_valid", 32'(dma_read_ctrl_valid), 32'd1);
                chk("ctrl_stable_index", dma_read_ctrl_data_index, pv_index);
                chk("ctrl_stable_len", dma_read_ctrl_data_length, pv_len);
            end
            pv_valid = dma_read_ctrl_valid;
            pv_ready = dma_read_ctrl_ready;
            pv_index = dma_read_ctrl_data_index;
            pv_len   = dma_read_ctrl_data_length;
            if (start && !busy) begin
                job_len  = cfg_len;
                exp_next = cfg_base_index;
                words    = 0;
                done_cnt = 0;
                req_log_idx.delete();
                req_log_len.delete();
            end
            if (dma_read_ctrl_valid && dma_read_ctrl_ready) begin
                chk("req_room", 32'(32'(occ) + dma_read_ctrl_data_length <= 32), 32'd1);
                req_log_idx.push_back(dma_read_ctrl_data_index);
                req_log_len.push_back(dma_read_ctrl_data_length);
                pend_idx.push_back(dma_read_ctrl_data_index);
                pend_len.push_back(dma_read_ctrl_data_length);
            end
            if (dma_read_chnl_valid && dma_read_chnl_ready) begin
                chk("no_overflow", 32'(occ < 32), 32'd1);
                occ++;
                cur_beats--;
                cur_idx++;
            end
            if (out_valid && out_ready) begin
                chk("out_data", out_data, word_of(exp_next));
                exp_next++;
                words++;
                occ--;
            end
            if (done) begin
                done_cnt++;
                chk("done_after_pop", 32'(words), job_len);
            end
            if (cur_beats == 0 && pend_len.size() != 0) begin
                cur_idx   = pend_idx.pop_front();
                cur_beats = int'(pend_len.pop_front());
            end
        end
    end

    // DMA data channel and core-side ready, driven away from the active edge
    always @(negedge clk) begin
        dma_read_chnl_valid = (cur_beats != 0) && (!chnl_rand || ($urandom_range(0, 3) != 0));
        dma_read_chnl_data  = (cur_beats != 0) ? word_of(cur_idx) : 32'h0;
        out_ready           = out_rand ? 1'($urandom_range(0, 1)) : out_en;
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_ctrl_valid"}, 32'(dma_read_ctrl_valid), 32'd0);
        chk({tag, "_ctrl_index"}, dma_read_ctrl_data_index, 32'd0);
        chk({tag, "_ctrl_len"}, dma_read_ctrl_data_length, 32'd0);
        chk({tag, "_ctrl_size"}, 32'(dma_read_ctrl_data_size), 32'd2);
        chk({tag, "_chnl_ready"}, 32'(dma_read_chnl_ready), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_data"}, out_data, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_debug"}, debug, 32'd0);
    endtask

    task automatic start_job(input logic [31:0] base, input logic [31:0] len);
        @(negedge clk);
        cfg_base_index = base;
        cfg_len        = len;
        start          = 1'b1;
        @(negedge clk);
        start          = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int c;
        c = 0;
        while (done_cnt == 0 && c < limit) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [31:0] e_idx [3];
        logic [31:0] e_len [3];
        e_idx = '{32'h100, 32'h110, 32'h120};
        e_len = '{32'd16, 32'd16, 32'd8};

        rst                 = 1'b0;
        start               = 1'b0;
        cfg_base_index      = 32'h0;
        cfg_len             = 32'h0;
        dma_read_ctrl_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset("rst");
        rst = 1'b1;
        @(negedge clk);

        // 40 words from 0x100: three bursts, last one short
        start_job(32'h100, 32'd40);
        wait_done("t1", 400);
        chk("t1_words", 32'(words), 32'd40);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);
        chk("t1_nreq", 32'(req_log_len.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("t1_req_idx", req_log_idx[i], e_idx[i]);
            chk("t1_req_len", req_log_len[i], e_len[i]);
        end
        chk("t1_debug", debug, 32'h0000_0003);
        chk("t1_busy", 32'(busy), 32'd0);

        // zero-length job: done next cycle, no request, never busy
        start_job(32'h55, 32'd0);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t2_done_clr", 32'(done), 32'd0);
        repeat (5) @(negedge clk);
        chk("t2_nreq", 32'(req_log_len.size()), 32'd0);
        chk("t2_ctrl_valid", 32'(dma_read_ctrl_valid), 32'd0);
        chk("t2_busy_idle", 32'(busy), 32'd0);
        chk("t2_done_cnt", 32'(done_cnt), 32'd1);

        // core stalled: two bursts fill the buffer, the third waits for space
        out_en = 1'b0;
        start_job(32'h2000, 32'd64);
        repeat (80) @(negedge clk);
        chk("t3_nreq_stalled", 32'(req_log_len.size()), 32'd2);
        chk("t3_words_stalled", 32'(words), 32'd0);
        chk("t3_occ", 32'(occ), 32'd32);
        chk("t3_out_valid", 32'(out_valid), 32'd1);
        chk("t3_ctrl_withheld", 32'(dma_read_ctrl_valid), 32'd0);
        chk("t3_busy", 32'(busy), 32'd1);
        out_en = 1'b1;
        wait_done("t3", 600);
        chk("t3_nreq", 32'(req_log_len.size()), 32'd4);
        chk("t3_words", 32'(words), 32'd64);
        chk("t3_done_cnt", 32'(done_cnt), 32'd1);
        chk("t3_debug", debug, 32'h0000_0004);

        // request held off by the DMA for five cycles
        dma_read_ctrl_ready = 1'b0;
        start_job(32'h300, 32'd4);
        for (int c = 0; c < 20 && !dma_read_ctrl_valid; c++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("t4_hold_valid", 32'(dma_read_ctrl_valid), 32'd1);
            chk("t4_hold_index", dma_read_ctrl_data_index, 32'h300);
            chk("t4_hold_len", dma_read_ctrl_data_length, 32'd4);
            if (k < 4) @(negedge clk);
        end
        dma_read_ctrl_ready = 1'b1;
        @(negedge clk);
        chk("t4_hs_nreq", 32'(req_log_len.size()), 32'd1);
        chk("t4_hs_valid_clr", 32'(dma_read_ctrl_valid), 32'd0);
        wait_done("t4", 200);
        chk("t4_words", 32'(words), 32'd4);

        // random gaps on both sides
        out_rand  = 1'b1;
        chnl_rand = 1'b1;
        start_job(32'h4000, 32'd100);
        wait_done("t5", 3000);
        chk("t5_words", 32'(words), 32'd100);
        chk("t5_done_cnt", 32'(done_cnt), 32'd1);
        chk("t5_debug", debug, 32'h0000_0007);
        out_rand  = 1'b0;
        chnl_rand = 1'b0;

        // reset in the middle of a data burst, then a fresh short job
        start_job(32'h5000, 32'd64);
        for (int c = 0; c < 50 && !dma_read_chnl_ready; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset("t6_rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_no_done", 32'(done_cnt), 32'd0);
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        start_job(32'h6000, 32'd4);
        wait_done("t6", 200);
        chk("t6_words", 32'(words), 32'd4);
        chk("t6_done_cnt", 32'(done_cnt), 32'd1);
        chk("t6_debug", debug, 32'h0000_0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hu_audiodec_dma_load.md
Name: hu_audiodec_dma_load

Overview:
Load stage for the hu_audiodec accelerator. It sits directly upstream of the audio decoder compute core.
- Converts a (base index, word count) job into a sequence of 32-bit ESP DMA read bursts.
- Buffers returned words in a local FIFO and streams them to the core over valid/ready.
- Signals completion once every word has been consumed downstream.

Parameters:
BURST_MAX, 16, maximum words per DMA read request (power of 2, >=1)
FIFO_DEPTH, 32, local buffer depth in words (power of 2, >= BURST_MAX)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
start  in  1  single-cycle job start pulse
cfg_base_index  in  32  first word index in accelerator memory space
cfg_len  in  32  total words to load
dma_read_ctrl_valid  out  1  read request valid
dma_read_ctrl_ready  in  1  read request accepted
dma_read_ctrl_data_index  out  32  request word index
dma_read_ctrl_data_length  out  32  request length in words
dma_read_ctrl_data_size  out  3  beat size; constant 3'b010 (32-bit)
dma_read_chnl_valid  in  1  read data beat valid
dma_read_chnl_ready  out  1  read data beat accepted
dma_read_chnl_data  in  32  read data beat
out_valid  out  1  word available to core
out_ready  in  1  core accepts word
out_data  out  32  word to core
busy  out  1  job in progress
done  out  1  one-cycle completion pulse
debug  out  32  [31:30] state, [29:16] 0, [15:0] bursts completed this job

Behaviour:
- Reset (rst low, asynchronous):
  - State IDLE, FIFO empty, all counters 0.
  - All outputs 0 except dma_read_ctrl_data_size = 3'b010.
  - Reset mid-job abandons the job; no done pulse is issued.
- IDLE:
  - start with cfg_len != 0: latch idx = cfg_base_index and rem = cfg_len, assert busy, go to REQ (registered, 1 cycle).
  - start with cfg_len == 0: done pulses in the next cycle; stay IDLE, busy stays 0.
  - start while busy is ignored.
- REQ:
  - burst = min(rem, BURST_MAX).
  - dma_read_ctrl_valid = 1 only when FIFO free slots >= burst, so a whole burst is always reserved.
  - index = idx, length = burst; both held stable while valid && !ready.
  - On handshake: beats = burst, go to DATA.
- DATA:
  - dma_read_chnl_ready = 1 while FIFO not full; it is 0 in every other state.
  - Each handshaken beat is pushed into the FIFO and decrements beats.
  - On the last beat: rem -= burst, idx += burst, burst counter += 1.
  - Next state is REQ if rem != 0, otherwise DRAIN.
- DRAIN: when FIFO is empty and no pop is pending, pulse done for one cycle, clear busy, go to IDLE.
- Output FIFO:
  - out_valid = !empty; out_data = head word.
  - Pop on out_valid && out_ready.
  - Push-to-visible latency is 1 cycle (word pushed in cycle N appears at out_data in N+1).
  - Simultaneous push and pop leaves count unchanged.
  - Push when full is impossible by construction; verification asserts it never happens.
- Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
- All arithmetic on idx and rem is 32-bit unsigned; no overflow check.
- Backpressure: out_ready low for any duration must never drop or duplicate a word. A request is withheld until enough space frees.

Decomposition:
- Shared package hu_audiodec_pkg holds:
  - state encoding (IDLE=0, REQ=1, DATA=2, DRAIN=3)
  - DMA_SIZE_WORD = 3'b010
  - default BURST_MAX / FIFO_DEPTH constants
- One sub-module: hu_audiodec_fifo.
  - Parameterised depth and width, synchronous push/pop, first-word fall-through.
  - Exposes count/full/empty and uses the same clk/rst.

Test Plan:
- cfg_base_index=0x100, cfg_len=40, out_ready=1, DMA always ready:
  - requests must be (0x100,16), (0x110,16), (0x120,8);
  - 40 words out in order; one done pulse; debug[15:0]=3.
- cfg_len=0 start: done pulses 1 cycle later; no ctrl_valid; busy stays 0.
- cfg_len=64, out_ready=0 throughout:
  - exactly 2 requests (FIFO fills to 32);
  - third request is withheld until out_ready=1 drains >=16 words;
  - no data loss.
- dma_read_ctrl_ready held low 5 cycles:
  - ctrl_valid, index and length stay stable across all 5 cycles;
  - the handshake completes on the first ready cycle.
- Random out_ready and chnl_valid gaps with cfg_len=100: output sequence matches the DMA data sequence exactly; done asserts only after the last pop.
- Assert rst low mid-DATA, then restart with cfg_len=4: all outputs return to reset values, FIFO is empty, and the new job completes normally.
